// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the CPU fetch and data channels.
// Single outstanding transaction; read data routed to the issuing channel.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   inst_*          : fetch request (addr/valid/ready) and response (rdata/valid/ready)
//   data_*          : load/store request (addr/rd/wr/wdata/wstrb/ready) and response
//   mem_*           : downstream request (valid/ready/addr/wen/wdata/wstrb)
//                     and read response (valid/data/ready)
//   conflict_cnt    : idle cycles in which both channels request
//   busy_cnt        : cycles spent outside IDLE
module mem_bus_arbiter #(
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr,
  input  logic        inst_req_valid,
  output logic        inst_req_ready,
  output logic [31:0] inst_rdata,
  output logic        inst_resp_valid,
  input  logic        inst_resp_ready,
  input  logic [31:0] data_addr,
  input  logic        data_rd,
  input  logic        data_wr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_req_ready,
  output logic [31:0] data_rdata,
  output logic        data_resp_valid,
  input  logic        data_resp_ready,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        mem_resp_ready,
  output logic [31:0] conflict_cnt,
  output logic [31:0] busy_cnt
);

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_REQ  = 3'b010;
  localparam logic [2:0] S_RESP = 3'b100;

  logic [2:0] state;
  logic [2:0] state_nxt;

  // grant / last_grant: 0 = inst, 1 = data
  logic grant;
  logic last_grant;
  logic data_req;
  logic any_req;
  logic both_req;
  logic win;

  assign data_req = data_rd | data_wr;
  assign any_req  = inst_req_valid | data_req;
  assign both_req = inst_req_valid & data_req;

  // Round-robin favours the channel not granted last time.
  always_comb begin
    win = 1'b0;
    if (both_req) begin
      win = DATA_PRIO ? 1'b1 : ~last_grant;
    end else begin
      win = data_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state[0]: begin
        if (any_req) state_nxt = S_REQ;
      end
      state[1]: begin
        if (mem_req_ready) state_nxt = mem_wen ? S_IDLE : S_RESP;
      end
      state[2]: begin
        if (mem_resp_valid && mem_resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_valid   = 1'b0;
    inst_req_ready  = 1'b0;
    data_req_ready  = 1'b0;
    mem_resp_ready  = 1'b0;
    inst_resp_valid = 1'b0;
    data_resp_valid = 1'b0;
    unique case (1'b1)
      state[1]: begin
        mem_req_valid  = 1'b1;
        inst_req_ready = ~grant & mem_req_ready;
        data_req_ready = grant & mem_req_ready;
      end
      state[2]: begin
        mem_resp_ready  = grant ? data_resp_ready : inst_resp_ready;
        inst_resp_valid = ~grant & mem_resp_valid;
        data_resp_valid = grant & mem_resp_valid;
      end
      default: ;
    endcase
  end

  assign inst_rdata = mem_resp_data;
  assign data_rdata = mem_resp_data;

  // Request latch; a simultaneous rd+wr is treated as a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else if (state[0] && any_req) begin
      grant      <= win;
      last_grant <= win;
      mem_addr   <= win ? data_addr : inst_addr;
      mem_wen    <= win & data_wr;
      mem_wdata  <= win ? data_wdata : '0;
      mem_wstrb  <= (win && data_wr) ? data_wstrb : 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
      busy_cnt     <= '0;
    end else begin
      if (state[0] && both_req) conflict_cnt <= conflict_cnt + 32'd1;
      if (!state[0]) busy_cnt <= busy_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter.
// Two instances: data-priority (u_dut) and round-robin (u_rr).
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic        inst_req_valid;
  logic        inst_req_ready;
  logic [31:0] inst_rdata;
  logic        inst_resp_valid;
  logic        inst_resp_ready;
  logic [31:0] data_addr;
  logic        data_rd;
  logic        data_wr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_req_ready;
  logic [31:0] data_rdata;
  logic        data_resp_valid;
  logic        data_resp_ready;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_ready;
  logic [31:0] conflict_cnt;
  logic [31:0] busy_cnt;

  logic        rr_inst_req_ready;
  logic [31:0] rr_inst_rdata;
  logic        rr_inst_resp_valid;
  logic        rr_data_req_ready;
  logic [31:0] rr_data_rdata;
  logic        rr_data_resp_valid;
  logic        rr_mem_req_valid;
  logic [31:0] rr_mem_addr;
  logic        rr_mem_wen;
  logic [31:0] rr_mem_wdata;
  logic [3:0]  rr_mem_wstrb;
  logic        rr_mem_resp_ready;
  logic [31:0] rr_conflict_cnt;
  logic [31:0] rr_busy_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DATA_PRIO(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_req_valid(inst_req_valid),
    .inst_req_ready(inst_req_ready), .inst_rdata(inst_rdata),
    .inst_resp_valid(inst_resp_valid), .inst_resp_ready(inst_resp_ready),
    .data_addr(data_addr), .data_rd(data_rd), .data_wr(data_wr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_req_ready(data_req_ready), .data_rdata(data_rdata),
    .data_resp_valid(data_resp_valid), .data_resp_ready(data_resp_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .mem_resp_ready(mem_resp_ready),
    .conflict_cnt(conflict_cnt), .busy_cnt(busy_cnt)
  );

  mem_bus_arbiter #(.DATA_PRIO(1'b0)) u_rr (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_req_valid(inst_req_valid),
    .inst_req_ready(rr_inst_req_ready), .inst_rdata(rr_inst_rdata),
    .inst_resp_valid(rr_inst_resp_valid), .inst_resp_ready(inst_resp_ready),
    .data_addr(data_addr), .data_rd(data_rd), .data_wr(data_wr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_req_ready(rr_data_req_ready), .data_rdata(rr_data_rdata),
    .data_resp_valid(rr_data_resp_valid), .data_resp_ready(data_resp_ready),
    .mem_req_valid(rr_mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(rr_mem_addr), .mem_wen(rr_mem_wen), .mem_wdata(rr_mem_wdata),
    .mem_wstrb(rr_mem_wstrb), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .mem_resp_ready(rr_mem_resp_ready),
    .conflict_cnt(rr_conflict_cnt), .busy_cnt(rr_busy_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    inst_addr = '0; inst_req_valid = 1'b0; inst_resp_ready = 1'b0;
    data_addr = '0; data_rd = 1'b0; data_wr = 1'b0;
    data_wdata = '0; data_wstrb = '0; data_resp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    tick();
    tick();
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wen", 32'(mem_wen), 32'd0);
    chk("rst_busy", busy_cnt, 32'd0);
    chk("rst_conflict", conflict_cnt, 32'd0);
    rst = 1'b0;

    // fetch only
    inst_addr = 32'h100; inst_req_valid = 1'b1;
    mem_req_ready = 1'b1; inst_resp_ready = 1'b1; data_resp_ready = 1'b1;
    #1;
    chk("f_latency", 32'(mem_req_valid), 32'd0);
    tick();
    #1;
    chk("f_req_valid", 32'(mem_req_valid), 32'd1);
    chk("f_addr", mem_addr, 32'h100);
    chk("f_wen", 32'(mem_wen), 32'd0);
    chk("f_wstrb", 32'(mem_wstrb), 32'd0);
    chk("f_iready", 32'(inst_req_ready), 32'd1);
    chk("f_dready", 32'(data_req_ready), 32'd0);
    tick();
    inst_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h2408000A;
    #1;
    chk("f_ivalid", 32'(inst_resp_valid), 32'd1);
    chk("f_irdata", inst_rdata, 32'h2408000A);
    chk("f_dvalid", 32'(data_resp_valid), 32'd0);
    chk("f_mresp_rdy", 32'(mem_resp_ready), 32'd1);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("f_busy", busy_cnt, 32'd2);
    chk("f_idle", 32'(mem_req_valid), 32'd0);

    // store with downstream stalled 3 cycles
    data_wr = 1'b1; data_addr = 32'h40;
    data_wdata = 32'hDEADBEEF; data_wstrb = 4'b0011;
    mem_req_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("s_valid", 32'(mem_req_valid), 32'd1);
      chk("s_wen", 32'(mem_wen), 32'd1);
      chk("s_addr", mem_addr, 32'h40);
      chk("s_wdata", mem_wdata, 32'hDEADBEEF);
      chk("s_wstrb", 32'(mem_wstrb), 32'h3);
      chk("s_dready_stall", 32'(data_req_ready), 32'd0);
      tick();
    end
    mem_req_ready = 1'b1;
    #1;
    chk("s_dready", 32'(data_req_ready), 32'd1);
    chk("s_wdata4", mem_wdata, 32'hDEADBEEF);
    tick();
    data_wr = 1'b0;
    mem_resp_valid = 1'b1;
    #1;
    chk("s_back_idle", 32'(mem_req_valid), 32'd0);
    chk("s_no_resp", 32'(mem_resp_ready), 32'd0);
    chk("s_no_dvalid", 32'(data_resp_valid), 32'd0);
    chk("s_busy", busy_cnt, 32'd6);
    mem_resp_valid = 1'b0;

    // conflict, data priority
    inst_addr = 32'h200; inst_req_valid = 1'b1;
    data_addr = 32'h80; data_rd = 1'b1;
    tick();
    chk("c_addr1", mem_addr, 32'h80);
    chk("c_dready", 32'(data_req_ready), 32'd1);
    chk("c_iready", 32'(inst_req_ready), 32'd0);
    chk("c_conflict", conflict_cnt, 32'd1);
    tick();
    data_rd = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h11112222;
    #1;
    chk("c_dvalid", 32'(data_resp_valid), 32'd1);
    chk("c_drdata", data_rdata, 32'h11112222);
    chk("c_ivalid", 32'(inst_resp_valid), 32'd0);
    tick();
    mem_resp_valid = 1'b0;
    #1;
    chk("c_gap_idle", 32'(mem_req_valid), 32'd0);
    tick();
    chk("c_addr2", mem_addr, 32'h200);
    chk("c_iready2", 32'(inst_req_ready), 32'd1);
    chk("c_conflict2", conflict_cnt, 32'd1);
    tick();
    inst_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h33334444;
    #1;
    chk("c_ivalid2", 32'(inst_resp_valid), 32'd1);
    tick();
    mem_resp_valid = 1'b0;

    // load with response backpressure
    data_rd = 1'b1; data_addr = 32'h44; data_resp_ready = 1'b0;
    tick();
    tick();
    data_rd = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFEF00D;
    #1;
    chk("b_mrdy0", 32'(mem_resp_ready), 32'd0);
    chk("b_dvalid0", 32'(data_resp_valid), 32'd1);
    tick();
    chk("b_mrdy1", 32'(mem_resp_ready), 32'd0);
    chk("b_dvalid1", 32'(data_resp_valid), 32'd1);
    chk("b_no_req", 32'(mem_req_valid), 32'd0);
    tick();
    data_resp_ready = 1'b1;
    #1;
    chk("b_mrdy2", 32'(mem_resp_ready), 32'd1);
    chk("b_rdata", data_rdata, 32'hCAFEF00D);
    tick();
    chk("b_idle_rdy", 32'(mem_resp_ready), 32'd0);
    chk("b_idle_dv", 32'(data_resp_valid), 32'd0);
    mem_resp_valid = 1'b0;

    // reset while in RESP
    data_rd = 1'b1; data_addr = 32'h48;
    tick();
    tick();
    data_rd = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h55556666;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("r_dvalid", 32'(data_resp_valid), 32'd0);
    chk("r_mrdy", 32'(mem_resp_ready), 32'd0);
    chk("r_mvalid", 32'(mem_req_valid), 32'd0);
    chk("r_ready", 32'({inst_req_ready, data_req_ready}), 32'd0);
    chk("r_conflict", conflict_cnt, 32'd0);
    chk("r_busy", busy_cnt, 32'd0);
    chk("r_addr", mem_addr, 32'h0);
    tick();
    chk("r_stale", 32'(data_resp_valid), 32'd0);
    chk("r_stale_rdy", 32'(mem_resp_ready), 32'd0);
    mem_resp_valid = 1'b0;

    // three simultaneous rounds: round-robin vs data priority
    inst_addr = 32'h300; inst_req_valid = 1'b1;
    data_addr = 32'h90; data_rd = 1'b1;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    mem_resp_data = 32'h77778888;
    tick();
    chk("rr_g1", rr_mem_addr, 32'h300);
    chk("rr_g1_ir", 32'(rr_inst_req_ready), 32'd1);
    chk("dp_g1", mem_addr, 32'h90);
    tick();
    tick();
    tick();
    chk("rr_g2", rr_mem_addr, 32'h90);
    chk("rr_g2_dr", 32'(rr_data_req_ready), 32'd1);
    chk("dp_g2", mem_addr, 32'h90);
    tick();
    tick();
    tick();
    chk("rr_g3", rr_mem_addr, 32'h300);
    chk("rr_g3_ir", 32'(rr_inst_req_ready), 32'd1);
    chk("dp_g3", mem_addr, 32'h90);
    chk("rr_conflict", rr_conflict_cnt, 32'd3);
    chk("dp_conflict", conflict_cnt, 32'd3);
    inst_req_valid = 1'b0; data_rd = 1'b0; mem_resp_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one unified memory port between the multi-cycle CPU's instruction-fetch channel and its data (load/store) channel.
- Arbitrates requests and allows at most one outstanding transaction.
- Routes each read response back to the requester that issued it. Writes need no response.
- Sits between custom_cpu and the memory/bus interface. Provides conflict and busy performance counters for the cpu_perf_cnt slots.

Parameters:
- DATA_PRIO, 1: 1 = data channel always wins a conflict; 0 = round-robin between the two channels.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- inst_addr  in  32  fetch address (PC)
- inst_req_valid  in  1  fetch request valid
- inst_req_ready  out  1  fetch request accepted
- inst_rdata  out  32  fetched instruction
- inst_resp_valid  out  1  instruction valid
- inst_resp_ready  in  1  CPU can accept the instruction
- data_addr  in  32  data address, word aligned
- data_rd  in  1  load request (MemRead)
- data_wr  in  1  store request (MemWrite)
- data_wdata  in  32  store data
- data_wstrb  in  4  store byte strobes
- data_req_ready  out  1  data request accepted
- data_rdata  out  32  load data
- data_resp_valid  out  1  load data valid
- data_resp_ready  in  1  CPU can accept load data
- mem_req_valid  out  1  downstream request valid
- mem_req_ready  in  1  downstream accepts request
- mem_addr  out  32  downstream address
- mem_wen  out  1  1 = write, 0 = read
- mem_wdata  out  32  downstream write data
- mem_wstrb  out  4  downstream strobes (0000 on reads)
- mem_resp_valid  in  1  downstream read data valid
- mem_resp_data  in  32  downstream read data
- mem_resp_ready  out  1  arbiter can accept read data
- conflict_cnt  out  32  IDLE cycles in which both channels request
- busy_cnt  out  32  cycles not in IDLE

Behaviour:
- Requests:
  - Data request = data_rd | data_wr.
  - If both are high, treat as a write.
  - Requesters hold valid and fields stable until *_req_ready.
- FSM (one-hot): IDLE, REQ, RESP.
  - Reset: state IDLE; grant register = inst; last-grant register = data; all valid/ready outputs 0; mem_addr/wdata/wstrb/wen 0; counters 0.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise choose a winner, latch grant, addr, wen, wdata and wstrb (wstrb forced to 0000 on reads), then go to REQ.
  - mem_req_valid first rises the cycle after the request is sampled (1-cycle arbitration latency).
- Conflict resolution:
  - DATA_PRIO=1: data wins.
  - DATA_PRIO=0: the channel not in last-grant wins, so inst wins the first conflict after reset.
  - Last-grant updates on every grant.
- REQ:
  - mem_req_valid=1 and latched fields are driven.
  - Granted *_req_ready = mem_req_ready (combinational); the other channel's ready stays 0.
  - On handshake: write goes to IDLE; read goes to RESP.
  - A write completes on acceptance and back-to-back grants are allowed after returning to IDLE.
- RESP:
  - mem_resp_ready = granted channel's *_resp_ready.
  - Granted *_resp_valid = mem_resp_valid; the other channel's resp_valid = 0.
  - inst_rdata and data_rdata both carry mem_resp_data.
  - On handshake go to IDLE.
  - The losing request stays pending and is arbitrated in the next IDLE cycle.
- Response timing: minimum read = 3 cycles from request sample to response handshake when downstream is ready immediately. A response arriving in the same cycle as mem_req_ready is not possible (one outstanding transaction).
- mem_resp_valid outside RESP is ignored; mem_resp_ready = 0 there.
- Counters:
  - conflict_cnt +1 in each IDLE cycle with both requests valid.
  - busy_cnt +1 in each REQ or RESP cycle.
  - Both wrap modulo 2^32.
- Reset mid-transaction: the in-flight transaction is dropped, state returns to IDLE, and responses until the next grant are ignored.

Test Plan:
- Fetch only: inst_addr=0x100, mem_req_ready=1, mem returns 0x2408000A one cycle after acceptance -> mem_req_valid at cycle 1; inst_req_ready pulses in the same cycle; inst_resp_valid=1 with inst_rdata=0x2408000A; data_resp_valid stays 0; busy_cnt=2.
- Store: data_wr=1, addr 0x40, wdata 0xDEADBEEF, strb 0011, mem_req_ready delayed 3 cycles -> mem_wen=1 and fields stable for all 4 REQ cycles; return to IDLE after acceptance; no RESP state entered.
- Conflict, DATA_PRIO=1: fetch 0x200 and load 0x80 raised the same cycle -> load is granted first; fetch is granted after the load response handshake; conflict_cnt=1.
- Conflict, DATA_PRIO=0: three consecutive simultaneous-request rounds -> grant order inst, data, inst.
- Response backpressure: data_resp_ready=0 for 2 cycles while mem_resp_valid=1 -> mem_resp_ready=0 and the FSM stays in RESP; handshake completes the cycle data_resp_ready rises.
- Reset asserted in RESP -> next cycle IDLE; all valid/ready outputs 0; conflict_cnt=busy_cnt=0; a stale mem_resp_valid is not forwarded.
